byte_stream_ctrl: RTL and testbench
===================================

# byte_stream_ctrl

Upstream stage of the seven-segment display controller: generates a stream of test bytes to a byte-wide transmitter (UART TX or similar) over a valid/ready handshake. Length is set from switches, and the inter-byte rate from speed up/down pulses. It also supplies the four 8-bit values the display shows:
- `num`: current byte.
- `speed`: rate setting.
- `num_of_bytes`: latched length.
- `byte_count`: bytes accepted so far.

## Interface
Parameters:
- `SPEED_MAX`, default 16: highest speed setting; range is 1..SPEED_MAX (≤255).
- `SPEED_INIT`, default 8: speed value after reset.
- `GAP_UNIT`, default 100000: clock cycles per gap unit (1 ms at 100 MHz).

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a transfer when idle.
- `abort`  in  1  one-cycle pulse; ends a transfer early.
- `speed_up`  in  1  one-cycle pulse (pre-debounced); speed +1.
- `speed_down`  in  1  one-cycle pulse (pre-debounced); speed −1.
- `len_sw`  in  8  requested byte count, sampled on `start`.
- `tx_ready`  in  1  downstream can accept a byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_data`  out  8  byte offered downstream.
- `num`  out  8  equals `tx_data` (display digits 0-1).
- `speed`  out  8  current speed setting (display digits 2-3).
- `num_of_bytes`  out  8  latched length (display digits 4-5).
- `byte_count`  out  8  handshakes completed in this transfer (display digits 6-7).
- `busy`  out  1  high in SEND and GAP states.
- `done`  out  1  one-cycle pulse at transfer end, normal or aborted.

## Operation
- **States:** IDLE, SEND, GAP, DONE.
- **IDLE**
  - `start` with `len_sw`≠0: latch `num_of_bytes`=`len_sw`, clear `byte_count`, reset the pattern to its seed, load the first byte, go to SEND.
  - `start` with `len_sw`=0: latch 0 and go to DONE. No bytes are sent.
- **SEND**
  - `tx_valid`=1; `tx_data` stays stable until the handshake (`tx_valid`&`tx_ready` at a rising edge).
  - On handshake, `byte_count`+1.
  - If the new count equals `num_of_bytes`, go to DONE; otherwise go to GAP and load the gap counter with G=(SPEED_MAX+1−speed)×GAP_UNIT.
- **GAP**
  - `tx_valid`=0; the counter decrements.
  - On expiry, advance the pattern to the next byte and return to SEND.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Outputs hold after a transfer:** `num_of_bytes`, `byte_count` and `num` keep their values until the next `start`.
- **Speed**
  - Updates in any state. Saturates at 1 and SPEED_MAX.
  - `speed_up`&`speed_down` in the same cycle: no change.
  - A change during a transfer takes effect at the next GAP load. A gap already running is not affected.
- **Abort**
  - In GAP: go to DONE on the next edge.
  - In SEND: the offered byte is not withdrawn. The block waits for the handshake (counted), then goes to DONE.
  - The abort request is latched until it is honoured.
  - In IDLE/DONE: ignored.
- **`start` while busy:** ignored.
- **Arithmetic:** all 8-bit unsigned. `byte_count` never exceeds `num_of_bytes`; `num_of_bytes`=255 gives a maximum of 255 bytes. The gap counter width is $clog2(SPEED_MAX×GAP_UNIT+1).

## Timing
- **Reset values:**
  - `tx_valid`, `tx_data`, `num`, `num_of_bytes`, `byte_count`, `busy`, `done`: 0.
  - `speed`: SPEED_INIT.
  - State: IDLE.
- **All outputs are registered.**
- **Start latency:** `start` sampled at edge k gives `tx_valid`=1 and `busy`=1 after edge k.
- **Inter-byte gap:** handshake at edge m gives `tx_valid`=0 after m, and `tx_valid`=1 again after edge m+G. Exactly G low cycles.
- **End of transfer:** the last handshake at edge m gives `done`=1 after m and `busy`=0 after m. `done` clears after m+1.
- **Speed latency:** `speed` updates one edge after the pulse.
- **Reset mid-transfer:** all registers return to their reset values immediately; `tx_valid` drops asynchronously.

## Configuration
- `BYTE_LFSR_PATTERN_EN` **defined:** bytes come from an 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seed 0x01. The first byte is 0x01.
- **Not defined:** bytes come from an incrementing counter. The first byte is 0x00, wrapping 0xFF→0x00.

## Structure
- **Package `byte_stream_pkg`** holds:
  - the state encoding;
  - the LFSR tap mask 8'hB8;
  - the LFSR seed 8'h01;
  - the default parameter values.
- **Sub-module `byte_pattern_gen`** holds the pattern register with `clk`/`reset`, a `load` pulse (seed) and an `advance` pulse. It holds the LFSR-vs-counter selection.
- **The top holds** the FSM, gap counter, speed register and counters.

## Test plan
Bench parameters: GAP_UNIT=4, SPEED_MAX=16, SPEED_INIT=8.

- **Basic transfer:** counter pattern, `len_sw`=3, `tx_ready`=1 → bytes 0x00,0x01,0x02; `tx_valid` low for 36 cycles between bytes; `done` pulse; `byte_count`=3, `num_of_bytes`=3.
- **Backpressure:** `tx_ready` held low for 10 cycles on byte 2 → `tx_data` stable at 0x01, `tx_valid` held high, no count until `tx_ready` rises.
- **Speed saturation and conflict:** 20 `speed_up` pulses → `speed`=16 and gap=4 cycles; 20 `speed_down` pulses → `speed`=1; simultaneous up+down → unchanged.
- **Abort:** abort during a GAP after 2 bytes of `len_sw`=10 → `done` next cycle, `byte_count`=2. Abort while SEND is stalled → waits for the handshake, `byte_count`=3.
- **Zero length and ignored start:** `len_sw`=0 → `done` pulse, no `tx_valid`. `start` while busy → ignored.
- **LFSR and reset:** with `BYTE_LFSR_PATTERN_EN`, `len_sw`=4 → 0x01 then successive LFSR states. Reset asserted mid-transfer → all outputs return to reset values and `speed`=8.

Source files
------------

// File: rtl/byte_stream_pkg.sv
// Shared types and constants for the byte stream controller.
// Pattern selection is controlled by the BYTE_LFSR_PATTERN_EN macro (see byte_pattern_gen).
package byte_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  localparam int SPEED_MAX_DEF  = 16;
  localparam int SPEED_INIT_DEF = 8;
  localparam int GAP_UNIT_DEF   = 100000;

  // Fibonacci step for x^8+x^6+x^5+x^4+1: feedback enters at bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/byte_pattern_gen.sv
// Test-byte pattern register: LFSR when BYTE_LFSR_PATTERN_EN is defined,
// otherwise an incrementing counter starting at 0x00.
module byte_pattern_gen
  import byte_stream_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic       advance_i,
  output logic [7:0] pattern_o
);

  logic [7:0] pattern_q;
  logic [7:0] pattern_d;
  logic [7:0] seed;
  logic [7:0] nextPattern;

`ifdef BYTE_LFSR_PATTERN_EN
  assign seed        = LFSR_SEED;
  assign nextPattern = lfsr_next(pattern_q);
`else
  assign seed        = 8'h00;
  assign nextPattern = pattern_q + 8'd1;
`endif

  always_comb begin
    pattern_d = pattern_q;
    if (load_i) begin
      pattern_d = seed;
    end else if (advance_i) begin
      pattern_d = nextPattern;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_q <= 8'h00;
    end else begin
      pattern_q <= pattern_d;
    end
  end

  assign pattern_o = pattern_q;

endmodule

// File: rtl/byte_stream_ctrl.sv
// Generates a paced stream of test bytes over valid/ready and exposes display values.
// Byte pattern chosen by BYTE_LFSR_PATTERN_EN (LFSR) or its absence (counter).
module byte_stream_ctrl #(
  parameter int SPEED_MAX  = byte_stream_pkg::SPEED_MAX_DEF,
  parameter int SPEED_INIT = byte_stream_pkg::SPEED_INIT_DEF,
  parameter int GAP_UNIT   = byte_stream_pkg::GAP_UNIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       speed_up,
  input  logic       speed_down,
  input  logic [7:0] len_sw,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic [7:0] num,
  output logic [7:0] speed,
  output logic [7:0] num_of_bytes,
  output logic [7:0] byte_count,
  output logic       busy,
  output logic       done
);
  import byte_stream_pkg::*;

  localparam int         GAP_W       = $clog2(SPEED_MAX * GAP_UNIT + 1);
  localparam logic [7:0] SPEED_MAX8  = 8'(SPEED_MAX);
  localparam logic [7:0] SPEED_INIT8 = 8'(SPEED_INIT);

  state_e           state_q;
  logic [7:0]       speed_q;
  logic [7:0]       speed_d;
  logic [7:0]       numBytes_q;
  logic [7:0]       byteCount_q;
  logic [GAP_W-1:0] gap_q;
  logic             abortPend_q;
  logic             txValid_q;
  logic             busy_q;
  logic             done_q;

  logic             loadPat;
  logic             advancePat;
  logic             handshake;
  logic             abortNow;
  logic             lastByte;
  logic [GAP_W-1:0] gapLoad;
  logic [7:0]       pattern;

  assign loadPat    = (state_q == ST_IDLE) && start && (len_sw != 8'd0);
  assign handshake  = (state_q == ST_SEND) && tx_ready;
  assign abortNow   = abort || abortPend_q;
  assign lastByte   = (byteCount_q + 8'd1) == numBytes_q;
  assign advancePat = (state_q == ST_GAP) && !abort && (gap_q == GAP_W'(1));

  // Gap length follows the speed register as it stands when the gap is loaded.
  assign gapLoad = GAP_W'((SPEED_MAX + 1 - int'(speed_q)) * GAP_UNIT);

  always_comb begin
    speed_d = speed_q;
    if (speed_up && !speed_down && (speed_q < SPEED_MAX8)) begin
      speed_d = speed_q + 8'd1;
    end else if (speed_down && !speed_up && (speed_q > 8'd1)) begin
      speed_d = speed_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      speed_q     <= SPEED_INIT8;
      numBytes_q  <= 8'd0;
      byteCount_q <= 8'd0;
      gap_q       <= '0;
      abortPend_q <= 1'b0;
      txValid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      speed_q <= speed_d;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          abortPend_q <= 1'b0;
          if (start) begin
            numBytes_q  <= len_sw;
            byteCount_q <= 8'd0;
            if (len_sw != 8'd0) begin
              state_q   <= ST_SEND;
              txValid_q <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (handshake) begin
            byteCount_q <= byteCount_q + 8'd1;
            txValid_q   <= 1'b0;
            if (lastByte || abortNow) begin
              state_q     <= ST_DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              abortPend_q <= 1'b0;
            end else begin
              state_q <= ST_GAP;
              gap_q   <= gapLoad;
            end
          end else if (abort) begin
            // The offered byte cannot be withdrawn, so remember the request.
            abortPend_q <= 1'b1;
          end
        end
        ST_GAP: begin
          if (abort) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            abortPend_q <= 1'b0;
          end else if (gap_q == GAP_W'(1)) begin
            state_q   <= ST_SEND;
            txValid_q <= 1'b1;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          abortPend_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  byte_pattern_gen u_pattern (
    .clk       (clk),
    .reset     (reset),
    .load_i    (loadPat),
    .advance_i (advancePat),
    .pattern_o (pattern)
  );

  assign tx_valid     = txValid_q;
  assign tx_data      = pattern;
  assign num          = pattern;
  assign speed        = speed_q;
  assign num_of_bytes = numBytes_q;
  assign byte_count   = byteCount_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_byte_stream_ctrl.sv
// Directed bench for byte_stream_ctrl with a byte scoreboard checked on every handshake.
module tb_byte_stream_ctrl;

  localparam int GAP_UNIT   = 4;
  localparam int SPEED_MAX  = 16;
  localparam int SPEED_INIT = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       speedUp;
  logic       speedDown;
  logic [7:0] lenSw;
  logic       txReady;
  logic       txValid;
  logic [7:0] txData;
  logic [7:0] num;
  logic [7:0] speed;
  logic [7:0] numOfBytes;
  logic [7:0] byteCount;
  logic       busy;
  logic       done;

  int         checkCount = 0;
  int         passCount  = 0;
  logic [7:0] expQ[$];
  logic [7:0] modelPat;
  logic [7:0] lastPushed;
  int         gapLen;

  always #5 clk = ~clk;

  byte_stream_ctrl #(
    .SPEED_MAX  (SPEED_MAX),
    .SPEED_INIT (SPEED_INIT),
    .GAP_UNIT   (GAP_UNIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .speed_up     (speedUp),
    .speed_down   (speedDown),
    .len_sw       (lenSw),
    .tx_ready     (txReady),
    .tx_valid     (txValid),
    .tx_data      (txData),
    .num          (num),
    .speed        (speed),
    .num_of_bytes (numOfBytes),
    .byte_count   (byteCount),
    .busy         (busy),
    .done         (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  function automatic logic [7:0] seedPattern();
`ifdef BYTE_LFSR_PATTERN_EN
    return 8'h01;
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [7:0] stepPattern(input logic [7:0] p);
`ifdef BYTE_LFSR_PATTERN_EN
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
`else
    return p + 8'd1;
`endif
  endfunction

  task automatic pushTransfer(input int n);
    modelPat = seedPattern();
    for (int i = 0; i < n; i++) begin
      expQ.push_back(modelPat);
      lastPushed = modelPat;
      modelPat   = stepPattern(modelPat);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic up, input logic dn, input logic [7:0] len);
    start     = st;
    abort     = ab;
    speedUp   = up;
    speedDown = dn;
    lenSw     = len;
    tick();
    start     = 1'b0;
    abort     = 1'b0;
    speedUp   = 1'b0;
    speedDown = 1'b0;
  endtask

  task automatic waitHandshake(input string tag);
    int i = 0;
    while (!(txValid && txReady) && i < 500) begin
      tick();
      i++;
    end
    checkOutput({tag, "_hs_seen"}, 32'(txValid && txReady), 32'd1);
    tick();
  endtask

  task automatic measureGap(output int n);
    n = 0;
    while (!txValid && n < 1000) begin
      tick();
      n++;
    end
  endtask

  // Scoreboard: every handshake must match the next queued byte.
  always @(negedge clk) begin
    if (reset && txValid && txReady) begin
      checkOutput("sb_entry", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        automatic logic [7:0] e = expQ.pop_front();
        checkOutput("tx_data", 32'(txData), 32'(e));
        checkOutput("num", 32'(num), 32'(e));
      end
    end
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    speedUp   = 1'b0;
    speedDown = 1'b0;
    lenSw     = 8'd0;
    txReady   = 1'b0;
    #12;
    checkOutput("rst_tx_valid", 32'(txValid), 32'd0);
    checkOutput("rst_tx_data", 32'(txData), 32'd0);
    checkOutput("rst_num", 32'(num), 32'd0);
    checkOutput("rst_speed", 32'(speed), 32'(SPEED_INIT));
    checkOutput("rst_num_of_bytes", 32'(numOfBytes), 32'd0);
    checkOutput("rst_byte_count", 32'(byteCount), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    #10 reset = 1'b1;
    tick();

    $display("[TB] basic transfer");
    txReady = 1'b1;
    pushTransfer(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    checkOutput("start_valid", 32'(txValid), 32'd1);
    checkOutput("start_busy", 32'(busy), 32'd1);
    waitHandshake("basic0");
    checkOutput("basic_count1", 32'(byteCount), 32'd1);
    checkOutput("basic_valid_low", 32'(txValid), 32'd0);
    measureGap(gapLen);
    checkOutput("basic_gap0", 32'(gapLen), 32'd36);
    waitHandshake("basic1");
    measureGap(gapLen);
    checkOutput("basic_gap1", 32'(gapLen), 32'd36);
    waitHandshake("basic2");
    checkOutput("basic_done", 32'(done), 32'd1);
    checkOutput("basic_busy_low", 32'(busy), 32'd0);
    checkOutput("basic_count3", 32'(byteCount), 32'd3);
    checkOutput("basic_nbytes", 32'(numOfBytes), 32'd3);
    tick();
    checkOutput("basic_done_clear", 32'(done), 32'd0);
    checkOutput("basic_num_hold", 32'(num), 32'(lastPushed));
    checkOutput("basic_count_hold", 32'(byteCount), 32'd3);

    $display("[TB] backpressure");
    pushTransfer(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    waitHandshake("bp0");
    txReady = 1'b0;
    measureGap(gapLen);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_valid_held", 32'(txValid), 32'd1);
      checkOutput("bp_data_stable", 32'(txData), 32'(expQ[0]));
      checkOutput("bp_no_count", 32'(byteCount), 32'd1);
      tick();
    end
    txReady = 1'b1;
    waitHandshake("bp1");
    checkOutput("bp_count2", 32'(byteCount), 32'd2);
    measureGap(gapLen);
    waitHandshake("bp2");
    checkOutput("bp_done", 32'(done), 32'd1);
    tick();

    $display("[TB] speed saturation");
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("speed_max", 32'(speed), 32'd16);
    pushTransfer(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    waitHandshake("fast0");
    measureGap(gapLen);
    checkOutput("fast_gap", 32'(gapLen), 32'd4);
    waitHandshake("fast1");
    checkOutput("fast_done", 32'(done), 32'd1);
    tick();
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    checkOutput("speed_min", 32'(speed), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("speed_up_one", 32'(speed), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    checkOutput("speed_conflict", 32'(speed), 32'd2);

    $display("[TB] abort in gap");
    pushTransfer(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd10);
    waitHandshake("ag0");
    measureGap(gapLen);
    checkOutput("slow_gap", 32'(gapLen), 32'd60);
    waitHandshake("ag1");
    repeat (3) tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("ag_done", 32'(done), 32'd1);
    checkOutput("ag_busy", 32'(busy), 32'd0);
    checkOutput("ag_count", 32'(byteCount), 32'd2);
    checkOutput("ag_nbytes", 32'(numOfBytes), 32'd10);
    checkOutput("ag_valid", 32'(txValid), 32'd0);
    tick();
    checkOutput("ag_done_clear", 32'(done), 32'd0);

    $display("[TB] abort in stalled send");
    pushTransfer(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd10);
    waitHandshake("as0");
    measureGap(gapLen);
    waitHandshake("as1");
    txReady = 1'b0;
    measureGap(gapLen);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    repeat (3) tick();
    checkOutput("as_busy_wait", 32'(busy), 32'd1);
    checkOutput("as_valid_wait", 32'(txValid), 32'd1);
    checkOutput("as_no_done", 32'(done), 32'd0);
    checkOutput("as_count_wait", 32'(byteCount), 32'd2);
    txReady = 1'b1;
    waitHandshake("as2");
    checkOutput("as_done", 32'(done), 32'd1);
    checkOutput("as_count", 32'(byteCount), 32'd3);
    checkOutput("as_busy", 32'(busy), 32'd0);
    tick();

    $display("[TB] zero length and ignored start");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    checkOutput("zero_valid", 32'(txValid), 32'd0);
    checkOutput("zero_nbytes", 32'(numOfBytes), 32'd0);
    checkOutput("zero_count", 32'(byteCount), 32'd0);
    tick();
    checkOutput("zero_done_clear", 32'(done), 32'd0);
    checkOutput("zero_valid_after", 32'(txValid), 32'd0);
    pushTransfer(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    waitHandshake("ig0");
    repeat (5) tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd9);
    checkOutput("ig_nbytes", 32'(numOfBytes), 32'd2);
    checkOutput("ig_busy", 32'(busy), 32'd1);
    measureGap(gapLen);
    waitHandshake("ig1");
    checkOutput("ig_done", 32'(done), 32'd1);
    checkOutput("ig_count", 32'(byteCount), 32'd2);
    tick();

    $display("[TB] pattern run of four");
    pushTransfer(4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    for (int i = 0; i < 3; i++) begin
      waitHandshake("pat");
      measureGap(gapLen);
    end
    waitHandshake("pat_last");
    checkOutput("pat_done", 32'(done), 32'd1);
    checkOutput("pat_num_last", 32'(num), 32'(lastPushed));
    tick();

    $display("[TB] reset mid-transfer");
    txReady = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    checkOutput("mid_valid", 32'(txValid), 32'd1);
    reset = 1'b0;
    #2;
    checkOutput("mid_rst_valid", 32'(txValid), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_data", 32'(txData), 32'd0);
    checkOutput("mid_rst_num", 32'(num), 32'd0);
    checkOutput("mid_rst_speed", 32'(speed), 32'(SPEED_INIT));
    checkOutput("mid_rst_nbytes", 32'(numOfBytes), 32'd0);
    checkOutput("mid_rst_count", 32'(byteCount), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    checkOutput("post_rst_valid", 32'(txValid), 32'd0);
    checkOutput("post_rst_speed", 32'(speed), 32'(SPEED_INIT));
    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
